// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, ALU control codes, FSM states and the control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [7:0] ALUOP_ADD   = 8'h08;
    localparam logic [7:0] ALUOP_ADDI  = 8'h09;
    localparam logic [7:0] ALUOP_SLT   = 8'h2A;
    localparam logic [7:0] ALUOP_SLTU  = 8'h2B;
    localparam logic [7:0] ALUOP_AND   = 8'h59;
    localparam logic [7:0] ALUOP_OR    = 8'h5A;
    localparam logic [7:0] ALUOP_XOR   = 8'h5B;
    localparam logic [7:0] ALUOP_LUI   = 8'h5C;
    localparam logic [7:0] ALUOP_FUNCT = 8'h02;
    localparam logic [7:0] ALUOP_ADDU  = 8'h21;
    localparam logic [7:0] ALUOP_SUBU  = 8'h23;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_IEXEC   = 4'd8,
        S_IWB     = 4'd9,
        S_BEQ     = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        C_MEM, C_RTYPE, C_ITYPE, C_BEQ, C_J, C_BAD
    } iclass_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [7:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
    } ctrl_t;

    // I-type opcodes 001000..001111 index this table by op[2:0]
    function automatic logic [7:0] itype_aluop(input logic [2:0] f);
        logic [7:0] r;
        unique case (f)
            3'd0:    r = ALUOP_ADD;
            3'd1:    r = ALUOP_ADDI;
            3'd2:    r = ALUOP_SLT;
            3'd3:    r = ALUOP_SLTU;
            3'd4:    r = ALUOP_AND;
            3'd5:    r = ALUOP_OR;
            3'd6:    r = ALUOP_XOR;
            default: r = ALUOP_LUI;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control-unit to datapath/memory bundle: opcode and memory
// handshake in, per-state control word out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [7:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;

    modport master (
        input  op, mem_ready,
        output memread, memwrite, iord, irwrite, pcwrite,
        output branch, pcsrc, alusrca, alusrcb, aluop,
        output regdst, memtoreg, regwrite, illegal
    );

    modport slave (
        output op, mem_ready,
        input  memread, memwrite, iord, irwrite, pcwrite,
        input  branch, pcsrc, alusrca, alusrcb, aluop,
        input  regdst, memtoreg, regwrite, illegal
    );
endinterface

// File: rtl/mc_ctrl_opdec.sv
// Opcode classifier: instruction class, store flag and the
// ALU code used by I-type execute.
module mc_opdec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output iclass_t    cls,
    output logic       is_store,
    output logic [7:0] ialuop
);

    always_comb begin
        cls      = C_BAD;
        is_store = 1'b0;
        ialuop   = itype_aluop(op[2:0]);
        unique case (1'b1)
            (op == OP_LW):     cls = C_MEM;
            (op == OP_SW): begin
                cls      = C_MEM;
                is_store = 1'b1;
            end
            (op == OP_RTYPE):  cls = C_RTYPE;
            (op == OP_BEQ):    cls = C_BEQ;
            (op == OP_J):      cls = C_J;
            (op[5:3] == 3'b001): cls = C_ITYPE;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: per-state control words,
// memory-ready stalls and a retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_ctrl_if.master        bus,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    state_t     cur;
    state_t     nxt;
    iclass_t    cls;
    logic       is_store;
    logic [7:0] ialuop;
    ctrl_t      c;
    ctrl_t      o;
    logic       retire;
    logic [CNT_W-1:0] cnt;

    mc_opdec u_opdec (
        .op       (bus.op),
        .cls      (cls),
        .is_store (is_store),
        .ialuop   (ialuop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= S_FETCH;
        else     cur <= nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cnt <= '0;
        else if (retire) cnt <= cnt + 1'b1;
    end

    always_comb begin
        nxt    = S_FETCH;
        c      = '0;
        retire = 1'b0;
        unique case (cur)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = 2'b01;
                c.aluop   = ALUOP_ADDU;
                c.irwrite = bus.mem_ready;
                c.pcwrite = bus.mem_ready;
                nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
                c.aluop   = ALUOP_ADDU;
                unique case (cls)
                    C_MEM:   nxt = S_MEMADR;
                    C_RTYPE: nxt = S_REXEC;
                    C_ITYPE: nxt = S_IEXEC;
                    C_BEQ:   nxt = S_BEQ;
                    C_J:     nxt = S_JUMP;
                    default: nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = ALUOP_ADDU;
                nxt = is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
                nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
                nxt    = bus.mem_ready ? S_FETCH : S_MEMWR;
                retire = bus.mem_ready;
            end
            S_REXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
                nxt = S_RWB;
            end
            S_RWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
                retire     = 1'b1;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = ialuop;
                nxt = S_IWB;
            end
            S_IWB: begin
                c.regwrite = 1'b1;
                retire     = 1'b1;
            end
            S_BEQ: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUBU;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
                retire    = 1'b1;
            end
            S_ILLEGAL: c.illegal = 1'b1;
            default: ;
        endcase
    end

    // Reset forces the whole control word quiet, even FETCH's memread
    assign o = rst ? '0 : c;

    assign bus.memread  = o.memread;
    assign bus.memwrite = o.memwrite;
    assign bus.iord     = o.iord;
    assign bus.irwrite  = o.irwrite;
    assign bus.pcwrite  = o.pcwrite;
    assign bus.branch   = o.branch;
    assign bus.pcsrc    = o.pcsrc;
    assign bus.alusrca  = o.alusrca;
    assign bus.alusrcb  = o.alusrcb;
    assign bus.aluop    = o.aluop;
    assign bus.regdst   = o.regdst;
    assign bus.memtoreg = o.memtoreg;
    assign bus.regwrite = o.regwrite;
    assign bus.illegal  = o.illegal;

    assign instret = cnt;
    assign state   = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed and random
// instruction traces against a per-instruction state-path model.
module tb_mc_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] instret;
    logic [3:0]   state;

    mc_ctrl_if bus ();

    mc_ctrl #(.CNT_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .instret (instret),
        .state   (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0] st;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [7:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
        logic [W-1:0] ret;
    } obs_t;

    int total = 0;
    int bad   = 0;
    int retired = 0;

    function automatic obs_t observe();
        obs_t r;
        r.st       = state;
        r.memread  = bus.memread;
        r.memwrite = bus.memwrite;
        r.iord     = bus.iord;
        r.irwrite  = bus.irwrite;
        r.pcwrite  = bus.pcwrite;
        r.branch   = bus.branch;
        r.pcsrc    = bus.pcsrc;
        r.alusrca  = bus.alusrca;
        r.alusrcb  = bus.alusrcb;
        r.aluop    = bus.aluop;
        r.regdst   = bus.regdst;
        r.memtoreg = bus.memtoreg;
        r.regwrite = bus.regwrite;
        r.illegal  = bus.illegal;
        r.ret      = instret;
        return r;
    endfunction

    function automatic logic [7:0] imm_alu(input logic [5:0] o);
        case (o)
            6'o10:   return 8'h08;
            6'o11:   return 8'h09;
            6'o12:   return 8'h2A;
            6'o13:   return 8'h2B;
            6'o14:   return 8'h59;
            6'o15:   return 8'h5A;
            6'o16:   return 8'h5B;
            default: return 8'h5C;
        endcase
    endfunction

    // Control word each state must show, straight from the state table
    function automatic obs_t expect_obs(input int st,
                                        input logic [5:0] o,
                                        input logic rdy);
        obs_t r;
        r = '0;
        r.st  = 4'(st);
        r.ret = W'(retired % (1 << W));
        case (st)
            0: begin
                r.memread = 1; r.alusrcb = 2'b01;
                r.aluop = 8'h21;
                r.irwrite = rdy; r.pcwrite = rdy;
            end
            1: begin r.alusrcb = 2'b11; r.aluop = 8'h21; end
            2: begin
                r.alusrca = 1; r.alusrcb = 2'b10;
                r.aluop = 8'h21;
            end
            3: begin r.memread = 1; r.iord = 1; end
            4: begin r.regwrite = 1; r.memtoreg = 1; end
            5: begin r.memwrite = 1; r.iord = 1; end
            6: begin r.alusrca = 1; r.aluop = 8'h02; end
            7: begin r.regwrite = 1; r.regdst = 1; end
            8: begin
                r.alusrca = 1; r.alusrcb = 2'b10;
                r.aluop = imm_alu(o);
            end
            9: r.regwrite = 1;
            10: begin
                r.alusrca = 1; r.aluop = 8'h23;
                r.pcsrc = 2'b01; r.branch = 1;
            end
            11: begin r.pcsrc = 2'b10; r.pcwrite = 1; end
            12: r.illegal = 1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check(input obs_t exp, input string tag);
        obs_t got;
        got = observe();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got st=%0d ctl=%h ret=%0d want st=%0d ctl=%h ret=%0d",
                   tag, got.st, got, got.ret, exp.st, exp, exp.ret);
        end
    endtask

    task automatic step(input int st, input logic [5:0] o,
                        input logic rdy, input string tag);
        @(negedge clk);
        bus.op = o;
        bus.mem_ready = rdy;
        #1;
        check(expect_obs(st, o, rdy), tag);
    endtask

    function automatic logic rb();
        return 1'($urandom % 2);
    endfunction

    // Walk one instruction through the state path the spec gives
    task automatic run_instr(input logic [5:0] o, input int fw,
                             input int mw, input string tag);
        bit ret = 1;
        repeat (fw) step(0, o, 1'b0, tag);
        step(0, o, 1'b1, tag);
        step(1, o, rb(), tag);
        if (o == 6'h23 || o == 6'h2B) begin
            step(2, o, rb(), tag);
            if (o == 6'h23) begin
                repeat (mw) step(3, o, 1'b0, tag);
                step(3, o, 1'b1, tag);
                step(4, o, rb(), tag);
            end else begin
                repeat (mw) step(5, o, 1'b0, tag);
                step(5, o, 1'b1, tag);
            end
        end else if (o == 6'h00) begin
            step(6, o, rb(), tag);
            step(7, o, rb(), tag);
        end else if (o[5:3] == 3'b001) begin
            step(8, o, rb(), tag);
            step(9, o, rb(), tag);
        end else if (o == 6'h04) begin
            step(10, o, rb(), tag);
        end else if (o == 6'h02) begin
            step(11, o, rb(), tag);
        end else begin
            step(12, o, rb(), tag);
            ret = 0;
        end
        if (ret) retired++;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 7))
            0: o = 6'h23;
            1: o = 6'h2B;
            2: o = 6'h00;
            3: o = 6'h04;
            4: o = 6'h02;
            5, 6: o = 6'(8 + $urandom_range(0, 7));
            default: begin
                o = 6'($urandom);
                while (o == 6'h23 || o == 6'h2B || o == 6'h00 ||
                       o == 6'h04 || o == 6'h02 || o[5:3] == 3'b001)
                    o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        obs_t z;
        rst = 1'b0;
        bus.op = 6'h00;
        bus.mem_ready = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk); #1;
        z = '0;
        check(z, "reset_state");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(expect_obs(0, 6'h00, 1'b0), "fetch_after_reset");

        run_instr(6'h09, 0, 0, "addiu");
        run_instr(6'h23, 0, 3, "lw_wait3");
        run_instr(6'h04, 0, 0, "beq");
        run_instr(6'h2B, 1, 2, "sw_wait");
        run_instr(6'h02, 0, 0, "j");
        run_instr(6'h00, 2, 0, "rtype");
        run_instr(6'h3F, 0, 0, "illegal");
        for (int i = 8; i < 16; i++)
            run_instr(6'(i), 0, 0, "itype_all");
        for (int i = 0; i < 10; i++)
            run_instr(6'h09, 0, 0, "wrap");

        for (int i = 0; i < 60; i++)
            run_instr(rand_op(), $urandom_range(0, 2),
                      $urandom_range(0, 3), "random");

        // Reset landing in the middle of a stalled load
        step(0, 6'h23, 1'b1, "rst_mid_fetch");
        step(1, 6'h23, 1'b0, "rst_mid_dec");
        step(2, 6'h23, 1'b0, "rst_mid_adr");
        step(3, 6'h23, 1'b0, "rst_mid_rd");
        #2 rst = 1'b1;
        #1;
        check(z, "rst_async");
        retired = 0;
        @(negedge clk); #1;
        check(z, "rst_held");
        rst = 1'b0;
        #1;
        check(expect_obs(0, 6'h23, 1'b0), "rst_release");
        run_instr(6'h2B, 0, 0, "sw_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
